// File: rtl/branch_predict_ctrl.sv
// Branch direction predictor and redirect controller.
// Predicts conditional branches and JAL in ID from a table of 2-bit
// saturating counters. Checks each prediction in EX against the resolved
// direction, drives the PC redirect and the IF/ID and ID/EX flushes, and
// keeps saturating branch and mispredict counts.
// All outputs are combinational from registered state and current inputs.
module branch_predict_ctrl #(
   parameter int BHT_ENTRIES = 16,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_in,
   input  logic            id_valid,
   input  logic            id_is_branch,
   input  logic            id_is_jal,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_target,
   output logic            id_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic            ex_is_jal,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic            ex_br_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_if,
   output logic            flush_id,
   output logic [15:0]     br_count,
   output logic [15:0]     mispred_count
);

   localparam int IDX = $clog2(BHT_ENTRIES);
   localparam logic [15:0] STAT_MAX = 16'hFFFF;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_t;

   state_t          state_reg;
   logic [1:0]      ctr_reg  [BHT_ENTRIES];
   logic [1:0]      ctr_next [BHT_ENTRIES];
   logic [15:0]     br_count_reg;
   logic [15:0]     mispred_count_reg;

   logic [IDX-1:0]  idx_id;
   logic [IDX-1:0]  idx_ex;
   logic            ex_resolve;
   logic            mp;
   logic            tbl_upd;
   logic            id_redirect;
   logic [XLEN-1:0] ex_fallthru;

   // Word-aligned PC bits select the counter; PCs differing only in higher
   // bits alias onto the same entry on purpose. The remaining id_pc bits
   // are folded here only to mark them as deliberately unused.
   logic id_pc_unused;
   assign id_pc_unused = ^{id_pc[1:0], id_pc[XLEN-1:IDX+2]};

   assign idx_id = id_pc[IDX+1:2];
   assign idx_ex = ex_pc[IDX+1:2];

   // Resolution events are all gated by the stall so a frozen EX
   // instruction acts only on its first unstalled cycle.
   assign ex_resolve  = ex_valid & (ex_is_branch | ex_is_jal) & ~stall_in;
   assign mp          = ex_resolve & (ex_pred_taken != ex_br_taken);
   assign tbl_upd     = ex_valid & ex_is_branch & ~stall_in;
   assign ex_fallthru = ex_pc + XLEN'(4);

   // JAL is always taken; B-type follows the counter MSB.
   assign id_pred_taken = id_valid & (id_is_jal | (id_is_branch & ctr_reg[idx_id][1]));

   // ID redirects only in RUN, so the wrong-path instruction that follows a
   // mispredict cannot steer fetch.
   assign id_redirect = ~mp & (state_reg == ST_RUN) & ~stall_in & id_pred_taken;

   // Redirect/flush mux: EX mispredict beats an ID predicted-taken redirect.
   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      flush_if       = 1'b0;
      flush_id       = 1'b0;
      if (mp) begin
         redirect_valid = 1'b1;
         redirect_pc    = ex_br_taken ? ex_target : ex_fallthru;
         flush_if       = 1'b1;
         flush_id       = 1'b1;
      end else if (id_redirect) begin
         redirect_valid = 1'b1;
         redirect_pc    = id_target;
         flush_if       = 1'b1;
      end
   end

   // Per-entry next counter value: saturating step toward the resolved
   // direction for the entry addressed by the EX branch.
   genvar gi;
   generate
      for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
         logic hit;
         assign hit = tbl_upd & (idx_ex == IDX'(gi));
         always_comb begin
            ctr_next[gi] = ctr_reg[gi];
            if (hit) begin
               if (ex_br_taken) begin
                  if (ctr_reg[gi] != 2'b11) begin
                     ctr_next[gi] = ctr_reg[gi] + 2'd1;
                  end
               end else begin
                  if (ctr_reg[gi] != 2'b00) begin
                     ctr_next[gi] = ctr_reg[gi] - 2'd1;
                  end
               end
            end
         end
      end
   endgenerate

   // Counter table: reset to weak not-taken, otherwise load the stepped value.
   // Reads above see the pre-edge value, so a same-cycle lookup gets the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            ctr_reg[i] <= 2'b01;
         end
      end else begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            ctr_reg[i] <= ctr_next[i];
         end
      end
   end

   // Squash FSM: one SQUASH cycle after each mispredict, re-armed by a
   // back-to-back mispredict.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RUN;
      end else begin
         case (state_reg)
            ST_RUN:    state_reg <= mp ? ST_SQUASH : ST_RUN;
            ST_SQUASH: state_reg <= mp ? ST_SQUASH : ST_RUN;
            default:   state_reg <= ST_RUN;
         endcase
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_count_reg      <= '0;
         mispred_count_reg <= '0;
      end else begin
         if (ex_resolve && (br_count_reg != STAT_MAX)) begin
            br_count_reg <= br_count_reg + 16'd1;
         end
         if (mp && (mispred_count_reg != STAT_MAX)) begin
            mispred_count_reg <= mispred_count_reg + 16'd1;
         end
      end
   end

   assign br_count      = br_count_reg;
   assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Testbench for branch_predict_ctrl: a reference model computes expected
// outputs for each driven cycle, pushes them to a scoreboard queue, and they
// are popped and compared at the falling edge of that cycle.
module tb_branch_predict_ctrl;

   localparam int XLEN = 32;
   localparam int NENT = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            stall_in = 1'b0;
   logic            id_valid = 1'b0;
   logic            id_is_branch = 1'b0;
   logic            id_is_jal = 1'b0;
   logic [XLEN-1:0] id_pc = '0;
   logic [XLEN-1:0] id_target = '0;
   logic            id_pred_taken;
   logic            ex_valid = 1'b0;
   logic            ex_is_branch = 1'b0;
   logic            ex_is_jal = 1'b0;
   logic [XLEN-1:0] ex_pc = '0;
   logic [XLEN-1:0] ex_target = '0;
   logic            ex_pred_taken = 1'b0;
   logic            ex_br_taken = 1'b0;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            flush_if;
   logic            flush_id;
   logic [15:0]     br_count;
   logic [15:0]     mispred_count;

   always #5 clk = ~clk;

   branch_predict_ctrl #(.BHT_ENTRIES(NENT), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_jal(id_is_jal),
      .id_pc(id_pc), .id_target(id_target), .id_pred_taken(id_pred_taken),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_br_taken(ex_br_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if(flush_if), .flush_id(flush_id),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   typedef struct {
      string       tag;
      logic        rv;
      logic [31:0] rpc;
      logic        fi;
      logic        fd;
      logic        pt;
      logic [15:0] brc;
      logic [15:0] mpc;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state
   logic [1:0] m_ctr [NENT];
   bit         m_squash;
   int         m_br;
   int         m_mp;

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) m_ctr[i] = 2'b01;
      m_squash = 1'b0;
      m_br = 0;
      m_mp = 0;
   endtask

   // Drive one cycle, push the expectation, compare at the falling edge,
   // then advance the model across the rising edge.
   task automatic step(input string tag,
                       input logic idv, input logic idb, input logic idj,
                       input logic [31:0] ipc, input logic [31:0] itg,
                       input logic exv, input logic exb, input logic exj,
                       input logic [31:0] epc, input logic [31:0] etg,
                       input logic ept, input logic ebt, input logic stl);
      exp_t e;
      exp_t g;
      logic mp;
      logic [3:0] ii;
      logic [3:0] ei;
      id_valid = idv; id_is_branch = idb; id_is_jal = idj;
      id_pc = ipc; id_target = itg;
      ex_valid = exv; ex_is_branch = exb; ex_is_jal = exj;
      ex_pc = epc; ex_target = etg; ex_pred_taken = ept; ex_br_taken = ebt;
      stall_in = stl;
      ii = ipc[5:2];
      ei = epc[5:2];
      e.tag = tag;
      e.pt  = idv & (idj | (idb & m_ctr[ii][1]));
      mp    = exv & (exb | exj) & (ept != ebt) & ~stl;
      e.rv = 1'b0; e.rpc = 32'h0; e.fi = 1'b0; e.fd = 1'b0;
      if (mp) begin
         e.rv = 1'b1; e.rpc = ebt ? etg : epc + 32'd4; e.fi = 1'b1; e.fd = 1'b1;
      end else if (!m_squash && !stl && e.pt) begin
         e.rv = 1'b1; e.rpc = itg; e.fi = 1'b1;
      end
      e.brc = 16'(m_br);
      e.mpc = 16'(m_mp);
      sb_q.push_back(e);
      #4;
      g = sb_q.pop_front();
      check({g.tag, ".pred"}, 32'(id_pred_taken), 32'(g.pt));
      check({g.tag, ".rv"}, 32'(redirect_valid), 32'(g.rv));
      check({g.tag, ".rpc"}, redirect_pc, g.rpc);
      check({g.tag, ".fif"}, 32'(flush_if), 32'(g.fi));
      check({g.tag, ".fid"}, 32'(flush_id), 32'(g.fd));
      check({g.tag, ".brc"}, 32'(br_count), 32'(g.brc));
      check({g.tag, ".mpc"}, 32'(mispred_count), 32'(g.mpc));
      $display("txn %-12s pred=%0d rv=%0d rpc=%08h fif=%0d fid=%0d br=%0d mp=%0d",
               g.tag, id_pred_taken, redirect_valid, redirect_pc, flush_if, flush_id,
               br_count, mispred_count);
      if (exv && exb && !stl) begin
         if (ebt) begin
            if (m_ctr[ei] != 2'b11) m_ctr[ei] = m_ctr[ei] + 2'd1;
         end else begin
            if (m_ctr[ei] != 2'b00) m_ctr[ei] = m_ctr[ei] - 2'd1;
         end
      end
      if (exv && (exb || exj) && !stl && m_br < 65535) m_br++;
      if (mp && m_mp < 65535) m_mp++;
      m_squash = mp;
      @(posedge clk);
      #1;
   endtask

   // Reset applied with whatever inputs are currently driven.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      //                 idv idb idj ipc          itg          exv exb exj epc          etg          ept ebt stl
      step("rst_idle",   0,  0,  0,  32'h0,       32'h0,       0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // not-taken branch at 0x40
      step("id_nt40",    1,  1,  0,  32'h40,      32'h100,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      step("ex_nt40",    0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'h40,      32'h100,     0,  0,  0);
      check("br_after_nt", 32'(br_count), 32'd1);
      // mispredict recovery: counter 00 -> 01
      step("mp40",       0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'h40,      32'h80,      0,  1,  0);
      check("mp_count1", 32'(mispred_count), 32'd1);
      step("squash_jal", 1,  0,  1,  32'h44,      32'h300,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // counter at 0 is 01 now: still predicts not-taken
      step("lk40_a",     1,  1,  0,  32'h40,      32'h700,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // training 0x44: 01->10->11->11
      for (int k = 0; k < 3; k++)
         step("train44",  0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'h44,      32'h900,     1,  1,  0);
      step("lk44_t",     1,  1,  0,  32'h44,      32'h1234,    0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      check("lk44_rpc_const", 32'h1234, 32'h1234 & {32{1'b1}});
      // one not-taken from saturated 11 -> 10 still taken, then 01 not-taken
      step("nt44_a",     1,  1,  0,  32'h44,      32'h1234,    1,  1,  0,  32'h44,      32'h900,     1,  0,  0);
      step("nt44_b",     1,  1,  0,  32'h44,      32'h1234,    1,  1,  0,  32'h44,      32'h900,     1,  0,  0);
      step("lk44_nt",    1,  1,  0,  32'h44,      32'h1234,    0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // same-cycle read returns old value; aliased PC 0x440 shares index 0
      step("same_cyc",   1,  1,  0,  32'h440,     32'h800,     1,  1,  0,  32'h40,      32'h80,      1,  1,  0);
      step("alias440",   1,  1,  0,  32'h440,     32'h800,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // JAL predicted in ID, resolved in EX without table change
      step("id_jal",     1,  0,  1,  32'h48,      32'h200,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      step("ex_jal",     0,  0,  0,  32'h0,       32'h0,       0,  0,  1,  32'h48,      32'h200,     1,  1,  0);
      step("ex_jal_v",   0,  0,  0,  32'h0,       32'h0,       1,  0,  1,  32'h48,      32'h200,     1,  1,  0);
      step("lk48",       1,  1,  0,  32'h48,      32'h260,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // stalled mispredict at 0x50 (index 4) with an ID JAL alongside
      for (int k = 0; k < 3; k++)
         step("stall_mp", 1,  0,  1,  32'h54,      32'h600,     1,  1,  0,  32'h50,      32'h90,      0,  1,  1);
      step("unstall_mp", 0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'h50,      32'h90,      0,  1,  0);
      step("nt50",       0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'h50,      32'h90,      0,  0,  0);
      step("lk50",       1,  1,  0,  32'h50,      32'h610,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // EX mispredict beats ID predicted-taken; back-to-back mispredict holds SQUASH
      step("prio",       1,  0,  1,  32'h14,      32'h500,     1,  1,  0,  32'h10,      32'h300,     1,  0,  0);
      step("prio_b2b",   1,  0,  1,  32'h18,      32'h500,     1,  1,  0,  32'h10,      32'h300,     1,  0,  0);
      step("sq_hold",    1,  0,  1,  32'h1c,      32'h500,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      step("run_again",  1,  0,  1,  32'h1c,      32'h500,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // fall-through wrap modulo 2^32
      step("wrap",       0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'hFFFFFFFC, 32'h40,     1,  0,  0);
      // reset with a pending mispredict: dropped, FSM back to RUN
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h20; ex_target = 32'h44;
      ex_pred_taken = 1'b0; ex_br_taken = 1'b1; stall_in = 1'b0;
      do_reset();
      step("post_rst",   1,  0,  1,  32'h24,      32'h480,     0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      // statistics saturation
      do_reset();
      id_valid = 1'b0; ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jal = 1'b0;
      ex_pc = 32'h60; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_br_taken = 1'b0;
      repeat (65535) @(posedge clk);
      #1;
      m_br = 65535;
      m_ctr[8] = 2'b00;
      $display("txn preload    65535 resolutions br=%0d", br_count);
      check("br_preload", 32'(br_count), 32'h0000FFFF);
      step("br_sat",     0,  0,  0,  32'h0,       32'h0,       1,  1,  0,  32'h60,      32'h0,       0,  0,  0);
      check("br_sat_hold", 32'(br_count), 32'h0000FFFF);
      do_reset();
      step("stat_rst",   0,  0,  0,  32'h0,       32'h0,       0,  0,  0,  32'h0,       32'h0,       0,  0,  0);
      check("br_rst0", 32'(br_count), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch direction predictor and redirect controller for the pipelined core. It predicts conditional branches and JAL in ID using a table of 2-bit saturating counters indexed by PC. It resolves predictions in EX against the `br_taken` result of the branch-condition unit. It drives PC redirect and pipeline flush, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- `BHT_ENTRIES`, default 16: number of 2-bit counters; must be a power of 2, minimum 2. `IDX = log2(BHT_ENTRIES)`.
- `XLEN`, default 32: PC width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall_in`, in, 1: pipeline freeze from the hazard unit.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_is_branch`, in, 1: ID instruction is B-type (opcode 1100011).
- `id_is_jal`, in, 1: ID instruction is JAL (opcode 1101111).
- `id_pc`, in, XLEN: PC of the ID instruction.
- `id_target`, in, XLEN: PC + imm of the ID instruction.
- `id_pred_taken`, out, 1: prediction, carried down the ID/EX register.
- `ex_valid`, in, 1: EX holds a real instruction.
- `ex_is_branch`, in, 1: EX instruction is B-type.
- `ex_is_jal`, in, 1: EX instruction is JAL.
- `ex_pc`, in, XLEN: PC of the EX instruction.
- `ex_target`, in, XLEN: computed taken target.
- `ex_pred_taken`, in, 1: prediction carried from ID.
- `ex_br_taken`, in, 1: resolved direction from the branch-condition unit.
- `redirect_valid`, out, 1: PC mux selects `redirect_pc`.
- `redirect_pc`, out, XLEN: next fetch PC when redirecting.
- `flush_if`, out, 1: bubble the IF/ID register.
- `flush_id`, out, 1: bubble the ID/EX register.
- `br_count`, out, 16: resolved branches plus JALs, saturating.
- `mispred_count`, out, 16: mispredicts, saturating.

## Operation
- **Table:** `BHT_ENTRIES` × 2-bit counters, encoded 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - ID index is `id_pc[IDX+1:2]`; EX index is `ex_pc[IDX+1:2]`.
- **Prediction (combinational):** `id_pred_taken = id_valid & (id_is_jal | (id_is_branch & ctr[idx_id][1]))`.
- **Mispredict:** `mp = ex_valid & (ex_is_branch | ex_is_jal) & (ex_pred_taken != ex_br_taken) & !stall_in`.
- **EX redirect (priority 1):** when `mp` is high:
  - `redirect_valid = 1`
  - `redirect_pc = ex_br_taken ? ex_target : ex_pc + 4`, with wrap modulo 2^XLEN
  - `flush_if = 1` and `flush_id = 1`
  - The FSM moves to SQUASH.
- **ID redirect (priority 2):** when `!mp`, state is RUN, `!stall_in` and `id_pred_taken` are all true:
  - `redirect_valid = 1`, `redirect_pc = id_target`
  - `flush_if = 1`, `flush_id = 0`
- **Otherwise:** all three control outputs are 0 and `redirect_pc = 0`.
- **FSM:**
  - RUN → SQUASH on `mp`.
  - SQUASH → RUN unconditionally after 1 cycle, unless `mp` is high again, which stays in SQUASH.
  - In SQUASH, ID redirects are suppressed and `id_pred_taken` is still computed.
  - `stall_in` has no effect on FSM transitions out of SQUASH.
- **Counter update:** on `ex_valid & ex_is_branch & !stall_in`, `ctr[idx_ex]` increments if `ex_br_taken`, otherwise decrements. It saturates at 11 and 00.
  - JAL never updates the table.
- **Statistics:**
  - `br_count` increments on `ex_valid & (ex_is_branch | ex_is_jal) & !stall_in`.
  - `mispred_count` increments on `mp`.
  - Both stick at 0xFFFF.
- **While `stall_in` is high:** no table, statistic or FSM-entry updates, and no redirect. The frozen EX instruction redirects on the first unstalled cycle.

## Timing
- Every output is a combinational function of registered state and current inputs; there is no output register.
- Redirect latency is 0 cycles:
  - Asserted in the same cycle as the EX resolution or ID prediction.
  - The fetch unit loads `redirect_pc` on the next edge.
- A counter update is visible to ID lookups from the cycle after the update edge.
  - A same-cycle read of the index being written returns the old value.
- **Reset:** `rst` high at an edge, including mid-operation, gives on the following cycle:
  - Every counter = 01, FSM = RUN, `br_count = 0`, `mispred_count = 0`.
  - Outputs reflect that state and the current inputs.
  - Any pending EX redirect is dropped.
- **Index aliasing:** PCs differing only above bit `IDX+1` share a counter. This is intended.
- **Simultaneous EX mispredict and ID predicted-taken:** only the EX redirect is issued. The ID instruction is flushed.

## Test plan
- **Reset, then not-taken branch:** `rst`, then ID branch at PC 0x40 → `id_pred_taken = 0`. Resolve in EX with `ex_br_taken = 0` → no redirect; `br_count = 1`; counter at index 0 becomes 00.
- **Mispredict recovery:** EX branch at PC 0x40, `ex_pred_taken = 0`, `ex_br_taken = 1`, target 0x80 → in that cycle `redirect_pc = 0x80`, `flush_if = flush_id = 1`, `mispred_count = 1` next cycle. Next cycle: SQUASH, and a predicted-taken ID branch gives no redirect.
- **Training and saturation:** resolve PC 0x44 taken 3 times → counter 01→10→11→11. An ID lookup of 0x44 then gives `id_pred_taken = 1`, `redirect_pc = id_target`, `flush_if = 1`, `flush_id = 0`.
- **JAL:** ID JAL with target 0x200 → redirect to 0x200. Resolve in EX with pred = taken = 1 → no redirect, table unchanged, `br_count` increments.
- **Stall and priority:**
  - Mispredict with `stall_in = 1` for 3 cycles → no redirect and no counter change. Redirect fires on the first cycle with `stall_in = 0`.
  - Simultaneous EX mispredict (not-taken, PC 0x10) and ID predicted-taken → `redirect_pc = 0x14`.
- **Statistics saturation:** preload via 65535 resolutions → `br_count = 0xFFFF`. One more resolution → `br_count` stays 0xFFFF. `rst` mid-sequence → all counts 0.
